// File: rtl/tl45_alu.sv
// rtl/tl45_alu.sv - tl45 execute stage: ALU, flags, jump resolution, forwarding, output buffer
// Define TL45_ALU_MUL_EN to build the shift-add multiplier; otherwise MUL is a decode error.
module tl45_alu (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pipe_stall,
   input  logic        i_pipe_flush,
   output logic        o_pipe_stall,
   output logic        o_pipe_flush,
   input  logic [4:0]  i_opcode,
   input  logic [3:0]  i_dr,
   input  logic [3:0]  i_jmp_cond,
   input  logic [31:0] i_sr1_val,
   input  logic [31:0] i_sr2_val,
   input  logic [31:0] i_target_address_offset,
   input  logic [31:0] i_pc,
   input  logic        i_decode_err,
   output logic [3:0]  o_of1_reg,
   output logic [31:0] o_of1_data,
   output logic [3:0]  o_of2_reg,
   output logic [31:0] o_of2_data,
   output logic [31:0] o_branch_pc,
   output logic [4:0]  o_opcode,
   output logic [3:0]  o_dr,
   output logic [31:0] o_value,
   output logic [31:0] o_pc,
   output logic        o_decode_err
);

   localparam logic [4:0] OP_NOP = 5'h00;
   localparam logic [4:0] OP_ADD = 5'h01;
   localparam logic [4:0] OP_SUB = 5'h02;
   localparam logic [4:0] OP_MUL = 5'h03;
   localparam logic [4:0] OP_OR  = 5'h04;
   localparam logic [4:0] OP_XOR = 5'h05;
   localparam logic [4:0] OP_AND = 5'h06;
   localparam logic [4:0] OP_SHL = 5'h07;
   localparam logic [4:0] OP_SHR = 5'h08;
   localparam logic [4:0] OP_JMP = 5'h0C;

   logic [3:0]  flags;   // {Z,N,C,V}
   logic        taken_q;
   logic [31:0] branch_pc_q;
   logic        flush;
   logic        is_mul;
   logic        is_jmp;

   assign flush  = i_pipe_flush | taken_q;
   assign is_mul = (i_opcode == OP_MUL);
   assign is_jmp = (i_opcode == OP_JMP);

   logic [32:0] sum;
   logic [32:0] diff;
   logic [31:0] alu_res;
   logic        alu_c;
   logic        alu_v;
   logic        alu_writes;

   always_comb begin
      sum        = {1'b0, i_sr1_val} + {1'b0, i_sr2_val};
      diff       = {1'b0, i_sr1_val} - {1'b0, i_sr2_val};
      alu_res    = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      alu_writes = 1'b1;
      case (i_opcode)
         OP_ADD: begin
            alu_res = sum[31:0];
            alu_c   = sum[32];
            alu_v   = (i_sr1_val[31] == i_sr2_val[31]) && (alu_res[31] != i_sr1_val[31]);
         end
         OP_SUB: begin
            // diff[32] is the borrow; C means no borrow (sr1 >= sr2 unsigned)
            alu_res = diff[31:0];
            alu_c   = ~diff[32];
            alu_v   = (i_sr1_val[31] != i_sr2_val[31]) && (alu_res[31] != i_sr1_val[31]);
         end
         OP_OR:   alu_res = i_sr1_val | i_sr2_val;
         OP_XOR:  alu_res = i_sr1_val ^ i_sr2_val;
         OP_AND:  alu_res = i_sr1_val & i_sr2_val;
         OP_SHL:  alu_res = i_sr1_val << i_sr2_val[4:0];
         OP_SHR:  alu_res = i_sr1_val >> i_sr2_val[4:0];
         default: alu_writes = 1'b0;
      endcase
   end

   logic fz, fn, fc, fv;
   logic cond_true;
   logic [31:0] target;

   assign {fz, fn, fc, fv} = flags;
   assign target = i_pc + i_target_address_offset;

   always_comb begin
      cond_true = 1'b0;
      case (i_jmp_cond)
         4'h0:    cond_true = 1'b1;
         4'h1:    cond_true = fz;
         4'h2:    cond_true = ~fz;
         4'h3:    cond_true = fc;
         4'h4:    cond_true = ~fc;
         4'h5:    cond_true = fn;
         4'h6:    cond_true = ~fn;
         4'h7:    cond_true = fv;
         4'h8:    cond_true = ~fv;
         4'h9:    cond_true = (fn != fv);
         4'hA:    cond_true = (fn == fv);
         4'hB:    cond_true = ~fz && (fn == fv);
         4'hC:    cond_true = fz || (fn != fv);
         default: cond_true = 1'b0;
      endcase
   end

   logic        mul_stall;
   logic        mul_done;
   logic        mul_err;
   logic [31:0] mul_result;

`ifdef TL45_ALU_MUL_EN
   typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;
   mul_state_t  mstate, mstate_nx;
   logic [4:0]  cnt;
   logic [31:0] mcand, mplier, prod;

   assign mul_err    = 1'b0;
   assign mul_result = prod;

   always_comb begin
      mstate_nx = mstate;
      mul_stall = 1'b0;
      mul_done  = 1'b0;
      case (mstate)
         M_IDLE: begin
            if (is_mul && !i_decode_err && !flush) begin
               mul_stall = 1'b1;
               if (!i_pipe_stall) mstate_nx = M_BUSY;
            end
         end
         M_BUSY: begin
            mul_stall = 1'b1;
            if (!i_pipe_stall && cnt == 5'd31) mstate_nx = M_DONE;
         end
         M_DONE: begin
            mul_done = 1'b1;
            if (!i_pipe_stall) mstate_nx = M_IDLE;
         end
         default: mstate_nx = M_IDLE;
      endcase
      if (flush || i_decode_err) mstate_nx = M_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mstate <= M_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else begin
         mstate <= mstate_nx;
         if (!flush && !i_decode_err && !i_pipe_stall) begin
            if (mstate == M_IDLE && mstate_nx == M_BUSY) begin
               mcand  <= i_sr1_val;
               mplier <= i_sr2_val;
               prod   <= '0;
               cnt    <= '0;
            end else if (mstate == M_BUSY) begin
               // one multiplier bit per cycle; only the low 32 product bits are kept
               if (mplier[0]) prod <= prod + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
            end
         end
      end
   end
`else
   assign mul_stall  = 1'b0;
   assign mul_done   = 1'b0;
   assign mul_err    = is_mul;
   assign mul_result = '0;
`endif

   logic        dec_err;
   logic        accept;
   logic        wr_now;
   logic [31:0] wr_value;

   assign dec_err  = i_decode_err | mul_err;
   assign accept   = !flush && !dec_err && !i_pipe_stall;
   assign wr_now   = alu_writes || (is_mul && mul_done);
   assign wr_value = is_mul ? mul_result : alu_res;

   assign o_of1_reg    = (accept && wr_now) ? i_dr : 4'd0;
   assign o_of1_data   = wr_value;
   assign o_of2_reg    = o_dr;
   assign o_of2_data   = o_value;
   assign o_branch_pc  = branch_pc_q;
   assign o_pipe_stall = i_pipe_stall | mul_stall;
   assign o_pipe_flush = flush;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_opcode     <= OP_NOP;
         o_dr         <= '0;
         o_value      <= '0;
         o_pc         <= '0;
         o_decode_err <= 1'b0;
         flags        <= '0;
         taken_q      <= 1'b0;
         branch_pc_q  <= '0;
      end else if (flush) begin
         o_opcode     <= OP_NOP;
         o_dr         <= '0;
         o_value      <= '0;
         o_pc         <= '0;
         o_decode_err <= 1'b0;
         taken_q      <= 1'b0;
      end else if (dec_err) begin
         o_opcode     <= OP_NOP;
         o_dr         <= '0;
         o_value      <= '0;
         o_pc         <= '0;
         o_decode_err <= 1'b1;
      end else if (!i_pipe_stall) begin
         o_decode_err <= 1'b0;
         o_pc         <= i_pc;
         if (is_jmp) begin
            o_opcode <= OP_JMP;
            o_dr     <= '0;
            o_value  <= '0;
            if (cond_true) begin
               taken_q     <= 1'b1;
               branch_pc_q <= target;
            end
         end else if (wr_now) begin
            o_opcode <= i_opcode;
            o_dr     <= i_dr;
            o_value  <= wr_value;
            flags    <= {(wr_value == 32'd0), wr_value[31], alu_c, alu_v};
         end else begin
            // NOP, unknown opcode, or a bubble while the multiplier works
            o_opcode <= OP_NOP;
            o_dr     <= '0;
            o_value  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tl45_alu.sv
// tb/tb_tl45_alu.sv - directed self-checking bench for tl45_alu
// Multiplier expectations follow TL45_ALU_MUL_EN.
module tb_tl45_alu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pipe_stall_in = 1'b0;
   logic        pipe_flush_in = 1'b0;
   logic        pipe_stall_out;
   logic        pipe_flush_out;
   logic [4:0]  opcode = '0;
   logic [3:0]  dr = '0;
   logic [3:0]  jmp_cond = '0;
   logic [31:0] sr1 = '0;
   logic [31:0] sr2 = '0;
   logic [31:0] offset = '0;
   logic [31:0] pc = '0;
   logic        decode_err_in = 1'b0;
   logic [3:0]  of1_reg, of2_reg, o_dr;
   logic [31:0] of1_data, of2_data, branch_pc, o_value, o_pc;
   logic [4:0]  o_opcode;
   logic        o_decode_err;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   tl45_alu dut (
      .i_clk(clk), .i_reset(reset),
      .i_pipe_stall(pipe_stall_in), .i_pipe_flush(pipe_flush_in),
      .o_pipe_stall(pipe_stall_out), .o_pipe_flush(pipe_flush_out),
      .i_opcode(opcode), .i_dr(dr), .i_jmp_cond(jmp_cond),
      .i_sr1_val(sr1), .i_sr2_val(sr2),
      .i_target_address_offset(offset), .i_pc(pc), .i_decode_err(decode_err_in),
      .o_of1_reg(of1_reg), .o_of1_data(of1_data),
      .o_of2_reg(of2_reg), .o_of2_data(of2_data),
      .o_branch_pc(branch_pc), .o_opcode(o_opcode), .o_dr(o_dr),
      .o_value(o_value), .o_pc(o_pc), .o_decode_err(o_decode_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [3:0] d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] off,
                        input logic [3:0] c);
      opcode = op; dr = d; sr1 = a; sr2 = b; pc = p; offset = off; jmp_cond = c;
      #1;
   endtask

   task automatic nop_cycle();
      drive(5'h00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
      tick();
   endtask

   logic [4:0]  lop [6] = '{5'h07, 5'h08, 5'h04, 5'h05, 5'h06, 5'h05};
   logic [31:0] la  [6] = '{32'h1, 32'h80000000, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h1234};
   logic [31:0] lb  [6] = '{32'h24, 32'd31, 32'h0FF0, 32'h0FF0, 32'h0FF0, 32'h1234};
   logic [31:0] lr  [6] = '{32'h10, 32'h1, 32'hFFF0, 32'hFF00, 32'h00F0, 32'h0};

   initial begin
      tick(); tick();
      check("rst_value", o_value, 0);
      check("rst_opcode", {27'd0, o_opcode}, 0);
      check("rst_dr", {28'd0, o_dr}, 0);
      check("rst_pc", o_pc, 0);
      check("rst_derr", {31'd0, o_decode_err}, 0);
      check("rst_bpc", branch_pc, 0);
      check("rst_stall", {31'd0, pipe_stall_out}, 0);
      check("rst_flush", {31'd0, pipe_flush_out}, 0);
      reset = 1'b0;

      // ADD overflow: flags Z0 N1 C0 V1
      drive(5'h01, 4'd3, 32'h7FFFFFFF, 32'h1, 32'h10, 32'd0, 4'd0);
      check("add_of1_reg", {28'd0, of1_reg}, 3);
      check("add_of1_data", of1_data, 32'h80000000);
      tick();
      check("add_value", o_value, 32'h80000000);
      check("add_dr", {28'd0, o_dr}, 3);
      check("add_opcode", {27'd0, o_opcode}, 1);
      check("add_pc", o_pc, 32'h10);
      check("add_of2_reg", {28'd0, of2_reg}, 3);
      check("add_of2_data", of2_data, 32'h80000000);

      drive(5'h0C, 4'd9, 32'd0, 32'd0, 32'h40, 32'h4, 4'd5);
      tick();
      check("jmp_n_flush", {31'd0, pipe_flush_out}, 1);
      check("jmp_n_bpc", branch_pc, 32'h44);
      check("jmp_n_opcode", {27'd0, o_opcode}, 32'h0C);
      check("jmp_n_dr", {28'd0, o_dr}, 0);
      drive(5'h01, 4'd5, 32'd1, 32'd1, 32'h48, 32'd0, 4'd0);
      check("squash_of1", {28'd0, of1_reg}, 0);
      tick();
      check("squash_opcode", {27'd0, o_opcode}, 0);
      check("squash_dr", {28'd0, o_dr}, 0);
      check("squash_flush_drop", {31'd0, pipe_flush_out}, 0);

      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h50, 32'h8, 4'd7);
      tick();
      check("jmp_v_flush", {31'd0, pipe_flush_out}, 1);
      nop_cycle();
      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h60, 32'h8, 4'd1);
      tick();
      check("jmp_z_nt", {31'd0, pipe_flush_out}, 0);
      check("jmp_z_nt_op", {27'd0, o_opcode}, 32'h0C);
      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h64, 32'h8, 4'd3);
      tick();
      check("jmp_c_nt", {31'd0, pipe_flush_out}, 0);

      // SUB 5-5: Z1 N0 C1 V0
      drive(5'h02, 4'd2, 32'd5, 32'd5, 32'h70, 32'd0, 4'd0);
      tick();
      check("sub_value", o_value, 0);
      check("sub_dr", {28'd0, o_dr}, 2);
      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h100, 32'h20, 4'd1);
      tick();
      check("jmp_eq_flush", {31'd0, pipe_flush_out}, 1);
      check("jmp_eq_bpc", branch_pc, 32'h120);
      drive(5'h01, 4'd4, 32'd1, 32'd1, 32'h104, 32'd0, 4'd0);
      check("jmp_eq_squash_of1", {28'd0, of1_reg}, 0);
      tick();
      check("jmp_eq_squash_op", {27'd0, o_opcode}, 0);
      check("jmp_eq_squash_dr", {28'd0, o_dr}, 0);
      drive(5'h0C, 4'd7, 32'd0, 32'd0, 32'h108, 32'h20, 4'd2);
      tick();
      check("jmp_ne_nt", {31'd0, pipe_flush_out}, 0);
      check("jmp_ne_op", {27'd0, o_opcode}, 32'h0C);
      check("jmp_ne_dr", {28'd0, o_dr}, 0);
      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h200, 32'hFFFFFFF0, 4'd3);
      tick();
      check("jmp_c_taken", {31'd0, pipe_flush_out}, 1);
      check("jmp_wrap_bpc", branch_pc, 32'h1F0);
      nop_cycle();

      // downstream stall holds buffer
      drive(5'h01, 4'd6, 32'd2, 32'd3, 32'h300, 32'd0, 4'd0);
      tick();
      check("add5_value", o_value, 5);
      pipe_stall_in = 1'b1;
      drive(5'h02, 4'd7, 32'd1, 32'd2, 32'h304, 32'd0, 4'd0);
      check("stall_out", {31'd0, pipe_stall_out}, 1);
      check("stall_of1", {28'd0, of1_reg}, 0);
      tick();
      check("stall_hold_value", o_value, 5);
      check("stall_hold_dr", {28'd0, o_dr}, 6);
      pipe_stall_in = 1'b0;
      #1;
      check("release_of1", {28'd0, of1_reg}, 7);
      tick();
      check("release_value", o_value, 32'hFFFFFFFF);
      check("release_dr", {28'd0, o_dr}, 7);
      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h308, 32'h4, 4'd4);
      tick();
      check("jmp_nc_taken", {31'd0, pipe_flush_out}, 1);
      nop_cycle();

      for (int i = 0; i < 6; i++) begin
         drive(lop[i], 4'd8, la[i], lb[i], 32'h400, 32'd0, 4'd0);
         tick();
         check($sformatf("logic%0d_value", i), o_value, lr[i]);
      end

      // decode error must not touch flags (Z stays 1 from the XOR)
      decode_err_in = 1'b1;
      drive(5'h01, 4'd9, 32'd1, 32'd1, 32'h500, 32'd0, 4'd0);
      check("derr_of1", {28'd0, of1_reg}, 0);
      tick();
      check("derr_flag", {31'd0, o_decode_err}, 1);
      check("derr_opcode", {27'd0, o_opcode}, 0);
      check("derr_value", o_value, 0);
      decode_err_in = 1'b0;
      drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h504, 32'h10, 4'd1);
      tick();
      check("derr_flags_held", {31'd0, pipe_flush_out}, 1);
      check("derr_cleared", {31'd0, o_decode_err}, 0);
      nop_cycle();

      drive(5'h0A, 4'd3, 32'd5, 32'd5, 32'h600, 32'd0, 4'd0);
      tick();
      check("unk_value", o_value, 0);
      check("unk_dr", {28'd0, o_dr}, 0);

`ifdef TL45_ALU_MUL_EN
      begin
         int n;
         drive(5'h03, 4'd10, 32'h10000, 32'h10001, 32'h700, 32'd0, 4'd0);
         n = 0;
         while (pipe_stall_out && n < 100) begin
            n++;
            tick();
         end
         check("mul_stall_cycles", n, 33);
         check("mul_done_of1", {28'd0, of1_reg}, 10);
         tick();
         check("mul_value", o_value, 32'h00010000);
         check("mul_dr", {28'd0, o_dr}, 10);
         drive(5'h0C, 4'd0, 32'd0, 32'd0, 32'h704, 32'h4, 4'd2);
         tick();
         check("mul_nz_flush", {31'd0, pipe_flush_out}, 1);
         nop_cycle();

         drive(5'h03, 4'd11, 32'd3, 32'd4, 32'h800, 32'd0, 4'd0);
         for (int k = 0; k < 5; k++) tick();
         check("mulf_busy", {31'd0, pipe_stall_out}, 1);
         pipe_flush_in = 1'b1;
         drive(5'h00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
         check("mulf_flush_out", {31'd0, pipe_flush_out}, 1);
         tick();
         pipe_flush_in = 1'b0;
         #1;
         check("mulf_stall_drop", {31'd0, pipe_stall_out}, 0);
         check("mulf_opcode", {27'd0, o_opcode}, 0);
         check("mulf_dr", {28'd0, o_dr}, 0);
      end
`else
      drive(5'h03, 4'd10, 32'h10000, 32'h10001, 32'h700, 32'd0, 4'd0);
      check("mul_nostall", {31'd0, pipe_stall_out}, 0);
      check("mul_of1", {28'd0, of1_reg}, 0);
      tick();
      check("mul_derr", {31'd0, o_decode_err}, 1);
      check("mul_opcode", {27'd0, o_opcode}, 0);
      check("mul_dr", {28'd0, o_dr}, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tl45_alu.md
# tl45_alu

Execute stage of the tl45 pipeline, directly downstream of register read. It consumes the register-read output buffer, computes ALU results and flags, and resolves conditional jumps. It drives both operand-forwarding buses back to register read, requests a pipeline flush on a taken jump, and holds results in a single output buffer for the memory stage.

## Interface
Parameters: none.
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_pipe_stall  in  1  downstream stall; hold output buffer
- i_pipe_flush  in  1  downstream flush; clear output buffer
- o_pipe_stall  out  1  i_pipe_stall OR multiply busy (upstream holds)
- o_pipe_flush  out  1  i_pipe_flush OR registered jump-taken
- i_opcode  in  5  operation
- i_dr  in  4  destination register (0 = none)
- i_jmp_cond  in  4  jump condition (JMP only)
- i_sr1_val, i_sr2_val  in  32  operands; sr2 already holds the immediate in RI mode
- i_target_address_offset  in  32  jump offset
- i_pc  in  32  instruction PC
- i_decode_err  in  1  upstream decode error
- o_of1_reg  out  4  forwarding bus 1 register, combinational, before buffer
- o_of1_data  out  32  forwarding bus 1 data
- o_of2_reg  out  4  forwarding bus 2 register, equals o_dr
- o_of2_data  out  32  forwarding bus 2 data, equals o_value
- o_branch_pc  out  32  jump target, valid while the registered taken bit is high
- o_opcode, o_dr  out  5/4  buffered opcode and destination
- o_value  out  32  buffered result
- o_pc  out  32  buffered PC
- o_decode_err  out  1  buffered decode error

## Operation
Opcodes:
- 0x00 NOP
- 0x01 ADD
- 0x02 SUB (sr1−sr2)
- 0x03 MUL
- 0x04 OR
- 0x05 XOR
- 0x06 AND
- 0x07 SHL
- 0x08 SHR (logical)
- 0x0C JMP
- Any other opcode acts as NOP with result 0.

Arithmetic:
- Shift amount is sr2[4:0].
- All results are 32-bit and wrap.

Flags register {Z,N,C,V}:
- Updated when an ADD through SHR or a MUL writes the output buffer.
- Z is set when the result is 0; N = result[31].
- C is the carry out for ADD and the borrow-free flag for SUB (sr1 ≥ sr2 unsigned). V is signed overflow. Both are 0 for all other ops.
- NOP, JMP and decode errors leave the flags unchanged.

JMP:
- Evaluates i_jmp_cond against the current flags register. The output buffer carries opcode 0x0C with o_dr = 0.
- Conditions: 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 V; 8 !V; 9 N≠V; A N=V; B !Z&&N=V; C Z||N≠V; D–F never.
- Target = i_pc + i_target_address_offset, wrapping.
- Taken: the taken bit and o_branch_pc are registered at the accepting edge, so o_pipe_flush is high for exactly one cycle after.
- During that cycle the stage ignores its inputs; that instruction is the squashed one.

Decode error: the output buffer is cleared to NOP and o_decode_err <= 1.

Forwarding:
- o_of1_reg = i_dr when the current input instruction writes a register and completes this cycle.
- Otherwise o_of1_reg = 0: NOP, JMP, multiply not in DONE, stall, self-flush cycle, or decode error.

Multiply FSM (IDLE, BUSY, DONE), shift-add at one bit per cycle:
- IDLE with MUL at input: stall high; latch operands; go to BUSY with cnt = 0.
- BUSY: stall high; cnt increments; at cnt = 31 go to DONE.
- DONE: multiply stall is low; the low 32 bits of the product are buffered at the next unstalled edge; return to IDLE.
- A flush (either source) or reset in any state returns the FSM to IDLE and discards the product.

## Timing
- Reset values:
  - All outputs 0, flags 0, FSM IDLE, taken bit 0.
  - o_pipe_stall and o_pipe_flush follow their inputs only.
- Single-cycle ops: inputs are accepted at edge t; the output buffer and o_of2 are valid from t+1.
- MUL presented at cycle 0: BUSY for cycles 1–32, DONE at cycle 33, result buffered at edge 33.
- A flags-setting op at edge t is visible to a JMP accepted at edge t+1.
- Priority:
  1. reset
  2. flush (i_pipe_flush or self-flush): clear buffer, hold flags
  3. decode error
  4. i_pipe_stall: hold everything, including DONE
  5. normal operation

## Configuration
- TL45_ALU_MUL_EN defined: the multiplier FSM is built as described.
- Not defined: no FSM. MUL is treated as a decode error (o_decode_err = 1, NOP buffered) and never stalls.

## Test plan
- ADD 0x7FFFFFFF + 1, dr = 3 -> o_value 0x80000000, o_dr 3; flags N = 1, V = 1, Z = 0, C = 0; o_of1_reg = 3 in the same cycle.
- SUB 5−5, then JMP cond 1 at pc 0x100, offset 0x20 -> o_pipe_flush high one cycle, o_branch_pc 0x120, next input ignored.
- JMP cond 2 with Z = 1 -> no flush; buffer holds opcode 0x0C with o_dr 0.
- MUL 0x10000 × 0x10001 (macro on) -> o_pipe_stall high for 33 cycles, o_value 0x00010000; Z = 0, N = 0.
- MUL in BUSY with i_pipe_flush pulsed -> FSM returns to IDLE, stall drops next cycle, buffer shows NOP.
- i_pipe_stall during ADD -> buffer and flags unchanged, o_pipe_stall high; release -> result appears.
